// File: rtl/predict_sequencer_pkg.sv
// Shared types and widths for the draw -> predict -> commit sequencer.
package predict_sequencer_pkg;
    localparam int COORD_W          = 4;
    localparam int DIGIT_W          = 4;
    localparam int GRID_MAX_DEFAULT = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_PRED = 3'd2,
        S_COMMIT    = 3'd3,
        S_CLEAR     = 3'd4
    } state_t;

    function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
        return (d != '0) && (d <= DIGIT_W'(9));
    endfunction
endpackage

// File: rtl/seq_timeout_counter.sv
// Counts enabled cycles from zero; expired flags the final allowed cycle.
module seq_timeout_counter #(
    parameter int LIMIT = 2000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

    assign expired = enable && (count == CW'(LIMIT - 1));
endmodule

// File: rtl/predict_sequencer.sv
// Turns a completed drawing into one predictor run and, if the digit is
// usable, one board write; always finishes by clearing the drawing track.
module predict_sequencer
    import predict_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int GRID_MAX       = GRID_MAX_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_active,
    input  logic               draw_valid,
    input  logic [COORD_W-1:0] draw_block_x,
    input  logic [COORD_W-1:0] draw_block_y,
    output logic               predict_start,
    input  logic               predict_finish,
    input  logic [DIGIT_W-1:0] predict_number,
    output logic               write_en,
    output logic [COORD_W-1:0] write_row,
    output logic [COORD_W-1:0] write_col,
    output logic [DIGIT_W-1:0] write_data,
    output logic               track_clear,
    output logic               busy,
    output logic               err_timeout,
    output logic               dropped
);
    state_t             state, state_next;
    logic [COORD_W-1:0] lat_x, lat_y;
    logic [DIGIT_W-1:0] lat_digit;
    logic               accept, in_range, expired;
    logic               predict_start_d, write_en_d, track_clear_d, err_timeout_d, dropped_d;

    seq_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != S_WAIT_PRED),
        .enable (state == S_WAIT_PRED),
        .expired(expired)
    );

    assign accept   = (state == S_IDLE) && draw_valid && game_active;
    assign in_range = (draw_block_x <= COORD_W'(GRID_MAX)) && (draw_block_y <= COORD_W'(GRID_MAX));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:
                if (accept) state_next = in_range ? S_LAUNCH : S_CLEAR;
            S_LAUNCH:
                state_next = game_active ? S_WAIT_PRED : S_CLEAR;
            S_WAIT_PRED:
                // Losing the game outranks a result arriving the same cycle.
                if (!game_active)
                    state_next = S_CLEAR;
                else if (predict_finish)
                    state_next = digit_ok(predict_number) ? S_COMMIT : S_CLEAR;
                else if (expired)
                    state_next = S_CLEAR;
            S_COMMIT:
                state_next = S_CLEAR;
            S_CLEAR:
                state_next = S_IDLE;
            default:
                state_next = S_IDLE;
        endcase
    end

    // Pulses are decoded from the next state so each is a clean flop output.
    always_comb begin
        predict_start_d = (state_next == S_LAUNCH);
        write_en_d      = (state_next == S_COMMIT);
        track_clear_d   = (state_next == S_CLEAR);
        err_timeout_d   = (state == S_WAIT_PRED) && game_active && !predict_finish && expired;
        dropped_d       = draw_valid && (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            predict_start <= 1'b0;
            write_en      <= 1'b0;
            track_clear   <= 1'b0;
            err_timeout   <= 1'b0;
            dropped       <= 1'b0;
            lat_x         <= '0;
            lat_y         <= '0;
            lat_digit     <= '0;
            write_row     <= '0;
            write_col     <= '0;
            write_data    <= '0;
        end else begin
            predict_start <= predict_start_d;
            write_en      <= write_en_d;
            track_clear   <= track_clear_d;
            err_timeout   <= err_timeout_d;
            dropped       <= dropped_d;
            if (accept) begin
                lat_x <= draw_block_x;
                lat_y <= draw_block_y;
            end
            if (write_en_d) begin
                lat_digit  <= predict_number;
                write_row  <= lat_y;
                write_col  <= lat_x;
                write_data <= predict_number;
            end
        end
    end

    assign busy = (state != S_IDLE);

    logic unused_ok;
    assign unused_ok = ^lat_digit;
endmodule

// File: tb/tb_predict_sequencer.sv
// Directed bench for predict_sequencer with hand-computed expectations.
module tb_predict_sequencer;
    logic       clk = 1'b0;
    logic       rst, game_active, draw_valid, predict_finish;
    logic [3:0] draw_block_x, draw_block_y, predict_number;
    logic       predict_start, write_en, track_clear, busy, err_timeout, dropped;
    logic [3:0] write_row, write_col, write_data;
    int         errors = 0, checks = 0;

    always #5 clk = ~clk;

    predict_sequencer #(.TIMEOUT_CYCLES(16), .GRID_MAX(8)) dut (
        .clk(clk), .rst(rst), .game_active(game_active), .draw_valid(draw_valid),
        .draw_block_x(draw_block_x), .draw_block_y(draw_block_y),
        .predict_start(predict_start), .predict_finish(predict_finish),
        .predict_number(predict_number), .write_en(write_en), .write_row(write_row),
        .write_col(write_col), .write_data(write_data), .track_clear(track_clear),
        .busy(busy), .err_timeout(err_timeout), .dropped(dropped)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then observed 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic draw(input logic [3:0] x, input logic [3:0] y);
        draw_valid = 1'b1; draw_block_x = x; draw_block_y = y;
        tick();
        draw_valid = 1'b0;
    endtask

    task automatic finish(input logic [3:0] d);
        predict_finish = 1'b1; predict_number = d;
        tick();
        predict_finish = 1'b0;
    endtask

    int pulses;

    initial begin
        rst = 1'b1; game_active = 1'b0; draw_valid = 1'b0; predict_finish = 1'b0;
        draw_block_x = '0; draw_block_y = '0; predict_number = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {predict_start, write_en, track_clear, err_timeout, dropped}, 0);
        chk("rst_wdata", {write_row, write_col, write_data}, 0);

        // Basic flow: draw at cycle 10, result at cycle 20.
        game_active = 1'b1;
        draw(4'd3, 4'd5);
        chk("t1_start", predict_start, 1);
        chk("t1_busy", busy, 1);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            pulses += int'(predict_start) + int'(write_en) + int'(track_clear);
        end
        chk("t1_quiet_wait", pulses, 0);
        finish(4'd7);
        chk("t1_wen", write_en, 1);
        chk("t1_wdata", {write_row, write_col, write_data}, 12'h537);
        tick();
        chk("t1_wen_pulse", write_en, 0);
        chk("t1_clear", track_clear, 1);
        chk("t1_hold", {write_row, write_col, write_data}, 12'h537);
        tick();
        chk("t1_idle", {busy, track_clear}, 0);

        // Out-of-range column: straight to CLEAR, no launch.
        draw(4'd9, 4'd2);
        chk("t2_nostart", predict_start, 0);
        chk("t2_clear", {track_clear, busy}, 2'b11);
        tick();
        chk("t2_idle", {track_clear, busy}, 0);

        // Timeout after 16 cycles in WAIT_PRED.
        draw(4'd1, 4'd1);
        tick();
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            pulses += int'(err_timeout) + int'(track_clear);
        end
        chk("t3_no_early_to", pulses, 0);
        tick();
        chk("t3_err", {err_timeout, track_clear}, 2'b11);
        tick();
        chk("t3_err_pulse", {err_timeout, busy}, 0);
        finish(4'd4);
        chk("t3_late_finish", {write_en, busy}, 0);
        chk("t3_hold", write_data, 4'd7);

        // Second draw while waiting is dropped; first coordinates are written.
        draw(4'd2, 4'd6);
        tick();
        draw(4'd8, 4'd8);
        chk("t4_dropped", dropped, 1);
        tick();
        chk("t4_dropped_pulse", dropped, 0);
        finish(4'd4);
        chk("t4_wen", write_en, 1);
        chk("t4_wdata", {write_row, write_col, write_data}, 12'h624);
        tick(); tick();
        chk("t4_idle", busy, 0);

        // Digit 0: no write, only the clear.
        draw(4'd1, 4'd1);
        tick();
        finish(4'd0);
        chk("t4_zero", {write_en, track_clear}, 2'b01);
        chk("t4_zero_hold", write_data, 4'd4);
        tick();

        // Draw and finish together in IDLE: the draw wins.
        draw_valid = 1'b1; draw_block_x = 4'd3; draw_block_y = 4'd3;
        predict_finish = 1'b1; predict_number = 4'd5;
        tick();
        draw_valid = 1'b0; predict_finish = 1'b0;
        chk("t5_both", {predict_start, write_en}, 2'b10);
        tick();
        finish(4'd2);
        chk("t5_wdata", {write_en, write_row, write_col, write_data}, 13'h1332);
        tick(); tick();

        // Game ends mid-wait: clear but no write.
        draw(4'd4, 4'd4);
        tick();
        game_active = 1'b0;
        tick();
        chk("t6_drop", {write_en, track_clear}, 2'b01);
        game_active = 1'b1;
        tick();
        chk("t6_idle", busy, 0);

        // Reset mid-wait: abort silently, outputs back to reset values.
        draw(4'd4, 4'd4);
        tick();
        rst = 1'b1;
        tick();
        chk("t7_rst_pulses", {write_en, track_clear, predict_start, err_timeout}, 0);
        chk("t7_rst_state", {busy, write_row, write_col, write_data}, 0);
        rst = 1'b0;
        tick();
        chk("t7_after", {busy, write_en, track_clear}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
